// File: rtl/decode_pkg.sv
// Shared definitions for the ARM data-processing decode stage: instruction
// field positions, opcode encodings and the rotated-immediate helper.
package decode_pkg;

  localparam int COND_HI = 31;
  localparam int COND_LO = 28;
  localparam int I_BIT   = 25;
  localparam int OPC_HI  = 24;
  localparam int OPC_LO  = 21;
  localparam int S_BIT   = 20;
  localparam int RN_HI   = 19;
  localparam int RN_LO   = 16;
  localparam int RD_HI   = 15;
  localparam int RD_LO   = 12;
  localparam int ROT_HI  = 11;
  localparam int ROT_LO  = 8;
  localparam int IMM_HI  = 7;
  localparam int IMM_LO  = 0;
  localparam int RM_HI   = 3;
  localparam int RM_LO   = 0;

  typedef enum logic [3:0] {
    OP_AND = 4'h0, OP_EOR = 4'h1, OP_SUB = 4'h2, OP_RSB = 4'h3,
    OP_ADD = 4'h4, OP_ADC = 4'h5, OP_SBC = 4'h6, OP_RSC = 4'h7,
    OP_TST = 4'h8, OP_TEQ = 4'h9, OP_CMP = 4'hA, OP_CMN = 4'hB,
    OP_ORR = 4'hC, OP_MOV = 4'hD, OP_BIC = 4'hE, OP_MVN = 4'hF
  } opcode_e;

  // Rotate right of a 32-bit value by n equals the low word of {x,x} >> n.
  function automatic logic [31:0] rot_imm(input logic [7:0] imm8, input logic [3:0] rot);
    logic [63:0] dbl;
    logic [4:0]  amt;
    amt = {rot, 1'b0};
    dbl = {24'd0, imm8, 24'd0, imm8} >> amt;
    return dbl[31:0];
  endfunction

endpackage

// File: rtl/decode_scoreboard.sv
// Pending-write mask for the decode stage: one bit per architectural register
// whose result is still in flight.
module decode_scoreboard (
  input  logic        clk,
  input  logic        rst,
  input  logic        set_en,
  input  logic [3:0]  set_addr,
  input  logic        clr_en,
  input  logic [3:0]  clr_addr,
  input  logic        kill_en,
  input  logic [3:0]  kill_addr,
  output logic [15:0] pending
);

  logic [15:0] pending_nxt;

  // Order sets priority: a new issue beats a retiring write, a flush beats both.
  always_comb begin
    pending_nxt = pending;
    if (clr_en)  pending_nxt[clr_addr]  = 1'b0;
    if (set_en)  pending_nxt[set_addr]  = 1'b1;
    if (kill_en) pending_nxt[kill_addr] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) pending <= '0;
    else     pending <= pending_nxt;
  end

endmodule

// File: rtl/decode_stage.sv
// Decode stage for ARM data-processing instructions with a register scoreboard.
// Optional build macro DECODE_FWD_EN forwards the writeback port into operands.
module decode_stage
  import decode_pkg::*;
#(
  parameter logic [3:0]  PC_REG   = 4'd15,
  parameter logic [31:0] PC_AHEAD = 32'd8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic [31:0] pc_in,
  output logic [3:0]  read_addr1,
  output logic [3:0]  read_addr2,
  input  logic [31:0] read_data1,
  input  logic [31:0] read_data2,
  input  logic        wb_we,
  input  logic [3:0]  wb_addr,
  input  logic [31:0] wb_data,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  cond,
  output logic [3:0]  opcode,
  output logic        set_flags,
  output logic        use_imm,
  output logic [3:0]  rd,
  output logic        rd_we,
  output logic [31:0] rn_val,
  output logic [31:0] op2_val
);

  logic [3:0]  rn_f, rm_f, rd_f, opc_f;
  logic        imm_f;
  logic        rn_used, rm_used, rn_fwd, rm_fwd, hazard, xfer, rd_we_d;
  logic [31:0] pc_ahead, rn_val_d, op2_val_d;
  logic [15:0] pending;

  logic        vld_p1, rd_we_p1, set_flags_p1, use_imm_p1;
  logic [3:0]  cond_p1, opcode_p1, rd_p1;
  logic [31:0] rn_val_p1, op2_val_p1;

  assign rn_f  = instr[RN_HI:RN_LO];
  assign rm_f  = instr[RM_HI:RM_LO];
  assign rd_f  = instr[RD_HI:RD_LO];
  assign opc_f = instr[OPC_HI:OPC_LO];
  assign imm_f = instr[I_BIT];

  assign read_addr1 = rn_f;
  assign read_addr2 = rm_f;

  // MOV/MVN ignore Rn; an immediate second operand means Rm is not read.
  assign rn_used = !(opc_f == OP_MOV || opc_f == OP_MVN);
  assign rm_used = !imm_f;
  assign rd_we_d = (opc_f[3:2] != 2'b10);
  assign pc_ahead = pc_in + PC_AHEAD;

`ifdef DECODE_FWD_EN
  assign rn_fwd = wb_we && (wb_addr == rn_f) && (rn_f != PC_REG);
  assign rm_fwd = wb_we && (wb_addr == rm_f) && (rm_f != PC_REG);
  logic [1:0] unused_bits;
  assign unused_bits = instr[27:26];
`else
  assign rn_fwd = 1'b0;
  assign rm_fwd = 1'b0;
  logic [33:0] unused_bits;
  assign unused_bits = {instr[27:26], wb_data};
`endif

  always_comb begin
    rn_val_d = read_data1;
    if (rn_f == PC_REG) rn_val_d = pc_ahead;
`ifdef DECODE_FWD_EN
    else if (rn_fwd)    rn_val_d = wb_data;
`endif
    op2_val_d = read_data2;
    if (imm_f)               op2_val_d = rot_imm(instr[IMM_HI:IMM_LO], instr[ROT_HI:ROT_LO]);
    else if (rm_f == PC_REG) op2_val_d = pc_ahead;
`ifdef DECODE_FWD_EN
    else if (rm_fwd)         op2_val_d = wb_data;
`endif
  end

  assign hazard = (rn_used && (rn_f != PC_REG) && pending[rn_f] && !rn_fwd) ||
                  (rm_used && (rm_f != PC_REG) && pending[rm_f] && !rm_fwd);

  assign in_ready = !rst && (!vld_p1 || out_ready) && !hazard && !flush;
  assign xfer     = in_valid && in_ready;

  decode_scoreboard u_sb (
    .clk       (clk),
    .rst       (rst),
    .set_en    (xfer && rd_we_d),
    .set_addr  (rd_f),
    .clr_en    (wb_we),
    .clr_addr  (wb_addr),
    .kill_en   (flush && vld_p1 && rd_we_p1),
    .kill_addr (rd_p1),
    .pending   (pending)
  );

  // ---- stage p1: decoded instruction handed to execute ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1       <= 1'b0;
      cond_p1      <= '0;
      opcode_p1    <= '0;
      set_flags_p1 <= 1'b0;
      use_imm_p1   <= 1'b0;
      rd_p1        <= '0;
      rd_we_p1     <= 1'b0;
      rn_val_p1    <= '0;
      op2_val_p1   <= '0;
    end else begin
      if (flush)                      vld_p1 <= 1'b0;
      else if (xfer)                  vld_p1 <= 1'b1;
      else if (vld_p1 && out_ready)   vld_p1 <= 1'b0;
      if (xfer) begin
        cond_p1      <= instr[COND_HI:COND_LO];
        opcode_p1    <= opc_f;
        set_flags_p1 <= instr[S_BIT];
        use_imm_p1   <= imm_f;
        rd_p1        <= rd_f;
        rd_we_p1     <= rd_we_d;
        rn_val_p1    <= rn_val_d;
        op2_val_p1   <= op2_val_d;
      end
    end
  end

  assign out_valid = vld_p1;
  assign cond      = cond_p1;
  assign opcode    = opcode_p1;
  assign set_flags = set_flags_p1;
  assign use_imm   = use_imm_p1;
  assign rd        = rd_p1;
  assign rd_we     = rd_we_p1;
  assign rn_val    = rn_val_p1;
  assign op2_val   = op2_val_p1;

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameter PC_REG, default 4'd15, index of the program-counter register.
REQ-002 SHALL have parameter PC_AHEAD, default 32'd8, offset added to pc_in when PC_REG is read.
REQ-003 SHALL have port clk, input, 1, the single clock; every register updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous reset, active-high.
REQ-005 SHALL have port in_valid, input, 1, instruction word present.
REQ-006 SHALL have port in_ready, output, 1, stage accepts the instruction this cycle.
REQ-007 SHALL have port instr, input, 32, ARM data-processing instruction word.
REQ-008 SHALL have port pc_in, input, 32, address of instr.
REQ-009 SHALL have ports read_addr1 and read_addr2, output, 4 each, combinational register-file read addresses (Rn and Rm).
REQ-010 SHALL have ports read_data1 and read_data2, input, 32 each, register-file read data.
REQ-011 SHALL have ports wb_we (1), wb_addr (4) and wb_data (32), inputs, the writeback port; it also feeds the register file.
REQ-012 SHALL have port flush, input, 1, kills the output slot.
REQ-013 SHALL have ports out_valid (output, 1) and out_ready (input, 1), the handshake to the execute stage.
REQ-014 SHALL have outputs cond (4), opcode (4), set_flags (1), use_imm (1), rd (4), rd_we (1), rn_val (32), op2_val (32), all registered.

Function
REQ-015 Instruction fields SHALL be decoded as: cond=[31:28], I=[25], opcode=[24:21], S=[20], Rn=[19:16], Rd=[15:12], Rm=[3:0], rot=[11:8], imm8=[7:0]; shift fields [11:4] SHALL be ignored when I=0.
REQ-016 read_addr1 SHALL equal Rn, and read_addr2 SHALL equal Rm, combinationally from instr.
REQ-017 When I=1, op2_val SHALL equal zero-extended imm8 rotated right by 2*rot, and Rm SHALL NOT be a source.
REQ-018 When I=0, op2_val SHALL equal the Rm operand value.
REQ-019 rd_we SHALL be 0 for opcodes 4'b1000 to 4'b1011 (TST/TEQ/CMP/CMN) and 1 otherwise.
REQ-020 Any source equal to PC_REG SHALL yield pc_in + PC_AHEAD, modulo 2^32, instead of read data.
REQ-021 A transfer SHALL occur when in_valid && in_ready; the output registers SHALL load on that edge and out_valid SHALL rise, giving 1-cycle latency.
REQ-022 in_ready SHALL equal (!out_valid || out_ready) && !hazard && !flush.
REQ-023 out_valid SHALL clear on out_valid && out_ready when no new transfer occurs, and SHALL hold with outputs stable while out_ready=0.
REQ-024 Scoreboard: a 16-bit pending mask SHALL set bit rd on a transfer with rd_we=1, and SHALL clear bit wb_addr when wb_we=1.
REQ-025 If the scoreboard sets and clears the same bit in one cycle, set SHALL win.
REQ-026 hazard SHALL be 1 when any used non-PC source register has its pending bit set, subject to the forwarding rule in the Configuration section.
REQ-027 flush SHALL clear out_valid on the next edge.
REQ-028 On flush, the pending bit of the killed instruction's rd SHALL clear if that instruction had rd_we=1.
REQ-029 flush SHALL take priority over a simultaneous transfer or writeback set.

Reset
REQ-030 While rst=1 at an edge, out_valid, all registered outputs and the pending mask SHALL become 0.
REQ-031 While rst=1, in_ready SHALL be 0.
REQ-032 rst asserted during a stall SHALL discard the stalled instruction and SHALL NOT leave any pending bit set.

Configuration
REQ-033 With DECODE_FWD_EN defined, a source register matching wb_addr while wb_we=1 SHALL take wb_data and SHALL NOT count as a hazard, even if its pending bit is set.
REQ-034 Without DECODE_FWD_EN, any set pending bit SHALL stall the instruction, and it SHALL transfer no earlier than the cycle after the clearing writeback.

Structure
REQ-035 Package decode_pkg SHALL hold the field bit positions, the opcode constants (AND..MVN) and a function computing the rotated immediate.
REQ-036 The pending mask and its set/clear/flush logic SHALL be a sub-module named decode_scoreboard.

Verification
REQ-037 Register file with r2=3; instr=32'hE2821003 (ADD r1,r2,#3) -> one cycle later out_valid=1, rn_val=3, op2_val=3, rd=1, rd_we=1, opcode=4'b0100.
REQ-038 instr=32'hE3A004FF (MOV r0,#0xFF000000) -> op2_val=32'hFF000000, use_imm=1.
REQ-039 instr=32'hE2821003 then 32'hE0813002 (ADD r3,r1,r2) -> in_ready=0 until wb_we=1, wb_addr=1, wb_data=32'h1234; with DECODE_FWD_EN the instruction transfers that cycle with rn_val=32'h1234; without, it transfers the next cycle.
REQ-040 instr=32'hE3510005 (CMP r1,#5) -> rd_we=0, set_flags=1, and a following reader of r0 is not stalled.
REQ-041 Issue 32'hE2821003, then flush=1 with out_ready=0 -> out_valid=0 and pending bit 1 clear next cycle; repeat with rst=1 instead of flush -> all outputs and the mask are 0.
REQ-042 pc_in=32'h100, instr=32'hE28F0004 (ADD r0,pc,#4) -> rn_val=32'h108.
